// File: rtl/prog_loader_if.sv
// prog_loader_if: UART byte stream and control pulses in, imem write port and CPU gating out.
// The master side drives rx_data/rx_valid/load_req/run_req; the loader is the slave.
interface prog_loader_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 15;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              load_req;
  logic              run_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [ADDR_W-1:0] imem_wdata;
  logic              cpu_en;
  logic              loading;
  logic              err;
  logic [CNT_W-1:0]  words_loaded;

  modport master (
    output rx_data, rx_valid, load_req, run_req,
    input  imem_we, imem_addr, imem_wdata, cpu_en, loading, err, words_loaded
  );

  modport slave (
    input  rx_data, rx_valid, load_req, run_req,
    output imem_we, imem_addr, imem_wdata, cpu_en, loading, err, words_loaded
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: assembles a UART length-prefixed frame into imem words and gates cpu_en.
// Define LOADER_CSUM_EN to require and check a trailing XOR checksum byte.
module prog_loader #(
  parameter logic [31:0] TEXT_BASE_ADDR = 32'h0040_0000,
  parameter int unsigned MAX_WORDS      = 16384,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input logic          clk,
  input logic          rst_n,
  prog_loader_if.slave bus
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 15;
  localparam int unsigned TMO_W  = 24;
  localparam int unsigned SH_W   = 24;

`ifdef LOADER_CSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERROR} state_t;
  localparam state_t S_DONE = S_CSUM;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_RUN, S_ERROR} state_t;
  localparam state_t S_DONE = S_RUN;
`endif

  state_t            state, state_nx;
  logic [1:0]        byte_cnt;
  logic [SH_W-1:0]   len_sh, word_sh;
  logic [CNT_W-1:0]  n_words, words_loaded;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              imem_we, cpu_en, loading, err;
  logic [ADDR_W-1:0] imem_addr, imem_wdata;
  logic [ADDR_W-1:0] len_nx, word_nx;
  logic              busy, busy_nx, tmo_hit, byte_take, last_word;
`ifdef LOADER_CSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  // Little-endian assembly: the incoming byte lands on top of the three already held.
  assign len_nx    = {bus.rx_data, len_sh};
  assign word_nx   = {bus.rx_data, word_sh};
  assign tmo_hit   = (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
  assign last_word = ((words_loaded + CNT_W'(1)) == n_words);
  assign byte_take = busy && bus.rx_valid && !bus.load_req;

`ifdef LOADER_CSUM_EN
  assign busy    = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign busy_nx = (state_nx == S_LEN) || (state_nx == S_DATA) || (state_nx == S_CSUM);
`else
  assign busy    = (state == S_LEN) || (state == S_DATA);
  assign busy_nx = (state_nx == S_LEN) || (state_nx == S_DATA);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state; load_req overrides everything.
  always_comb begin
    state_nx = state;
    if (bus.load_req) begin
      state_nx = S_LEN;
    end else begin
      case (state)
        S_IDLE: if (bus.run_req) state_nx = S_RUN;
        S_LEN: begin
          if (bus.rx_valid) begin
            if (byte_cnt == 2'd3) begin
              if (len_nx > 32'(MAX_WORDS)) state_nx = S_ERROR;
              else if (len_nx == '0)       state_nx = S_DONE;
              else                         state_nx = S_DATA;
            end
          end else if (tmo_hit) begin
            state_nx = S_ERROR;
          end
        end
        S_DATA: begin
          if (bus.rx_valid) begin
            if (byte_cnt == 2'd3 && last_word) state_nx = S_DONE;
          end else if (tmo_hit) begin
            state_nx = S_ERROR;
          end
        end
`ifdef LOADER_CSUM_EN
        S_CSUM: begin
          if (bus.rx_valid)  state_nx = (bus.rx_data == csum) ? S_RUN : S_ERROR;
          else if (tmo_hit)  state_nx = S_ERROR;
        end
`endif
        default: state_nx = state;
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt     <= '0;
      len_sh       <= '0;
      word_sh      <= '0;
      n_words      <= '0;
      words_loaded <= '0;
      tmo_cnt      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_en       <= 1'b0;
      loading      <= 1'b0;
      err          <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum         <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      cpu_en  <= (state_nx == S_RUN);
      loading <= busy_nx;
      err     <= (state_nx == S_ERROR);
      if (bus.load_req) begin
        byte_cnt     <= '0;
        n_words      <= '0;
        words_loaded <= '0;
        tmo_cnt      <= '0;
`ifdef LOADER_CSUM_EN
        csum         <= '0;
`endif
      end else begin
        tmo_cnt <= (busy && !bus.rx_valid) ? tmo_cnt + TMO_W'(1) : '0;
        if (byte_take) begin
          byte_cnt <= byte_cnt + 2'd1;
          if (state == S_LEN) begin
            len_sh <= len_nx[ADDR_W-1:BYTE_W];
            if (byte_cnt == 2'd3) n_words <= CNT_W'(len_nx);
          end
          if (state == S_DATA) begin
            word_sh <= word_nx[ADDR_W-1:BYTE_W];
`ifdef LOADER_CSUM_EN
            csum    <= csum ^ bus.rx_data;
`endif
            // Depth guard keeps writes inside the text window even if n_words were corrupted.
            if (byte_cnt == 2'd3 && 32'(words_loaded) < 32'(MAX_WORDS)) begin
              imem_we      <= 1'b1;
              imem_addr    <= TEXT_BASE_ADDR + ADDR_W'({words_loaded, 2'b00});
              imem_wdata   <= word_nx;
              words_loaded <= words_loaded + CNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign bus.imem_we      = imem_we;
  assign bus.imem_addr    = imem_addr;
  assign bus.imem_wdata   = imem_wdata;
  assign bus.cpu_en       = cpu_en;
  assign bus.loading      = loading;
  assign bus.err          = err;
  assign bus.words_loaded = words_loaded;
endmodule
